// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    // Operation select on the op port.
    localparam logic MDU_MUL = 1'b0;
    localparam logic MDU_DIV = 1'b1;

    // Fill bit for the lo value returned on a divide by zero (all-ones).
    localparam logic MDU_ZERO_LO_BIT = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes (neg = operand is negative) and to restore result signs.
module mdu_signfix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    logic signed [WIDTH-1:0] val_s;
    logic signed [WIDTH-1:0] neg_s;

    // Negate when requested; the most-negative value maps onto itself,
    // which read as unsigned is exactly its magnitude.
    always_comb begin
        val_s = signed'(val);
        neg_s = -val_s;
        res   = neg ? unsigned'(neg_s) : val;
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with start/busy/done handshake and cancel.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] ZERO_LO = {WIDTH{MDU_ZERO_LO_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic             cancel,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Control / output state (reset)
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Datapath state (loaded at acceptance, no reset needed)
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               op_q, op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;

    // Operand magnitudes and result fix-ups
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    mdu_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .val (opa),
        .neg (sgn & opa[WIDTH-1]),
        .res (abs_a)
    );

    mdu_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .val (opb),
        .neg (sgn & opb[WIDTH-1]),
        .res (abs_b)
    );

    mdu_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val (acc_q),
        .neg (neg_res_q),
        .res (prod_fix)
    );

    mdu_signfix #(.WIDTH(WIDTH)) u_fix_quo (
        .val (acc_q[WIDTH-1:0]),
        .neg (neg_res_q),
        .res (quo_fix)
    );

    mdu_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .val (acc_q[2*WIDTH-1:WIDTH]),
        .neg (neg_rem_q),
        .res (rem_fix)
    );

    // Single iteration step: acc holds {partial, operand bits still to consume}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    op_d      = op;
                    neg_res_d = sgn & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    neg_rem_d = sgn & opa[WIDTH-1];
                    cnt_d     = '0;
                    if (op == MDU_DIV && opb == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                        hi_d    = opa;
                        lo_d    = ZERO_LO;
                    end else begin
                        state_d = ST_CALC;
                        busy_d  = 1'b1;
                        // Accumulator low half starts with the operand that is
                        // consumed bit by bit; mcand is the one added/subtracted.
                        mcand_d = (op == MDU_DIV) ? abs_b : abs_a;
                        acc_d   = {{WIDTH{1'b0}}, ((op == MDU_DIV) ? abs_a : abs_b)};
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = (op_q == MDU_DIV) ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (op_q == MDU_DIV) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Start is deliberately ignored here; cancel cannot suppress done.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Datapath registers; always loaded before use, so no reset.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        mcand_q   <= mcand_d;
        op_q      <= op_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomised scoreboard bench for mdu_iter (32-bit instance) plus a
// directed 8-bit instance for narrow-width and reset-abort behaviour.
module tb_mdu_iter;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // 32-bit instance
    logic        rst32 = 1'b0;
    logic        start32 = 1'b0, op32 = 1'b0, sgn32 = 1'b0, cancel32 = 1'b0;
    logic [31:0] opa32 = '0, opb32 = '0;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;

    mdu_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst32), .start(start32), .op(op32), .sgn(sgn32),
        .cancel(cancel32), .opa(opa32), .opb(opb32), .busy(busy32),
        .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
    );

    // 8-bit instance
    logic       rst8 = 1'b0;
    logic       start8 = 1'b0, op8 = 1'b0, sgn8 = 1'b0, cancel8 = 1'b0;
    logic [7:0] opa8 = '0, opb8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] hi8, lo8;

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .sgn(sgn8),
        .cancel(cancel8), .opa(opa8), .opb(opb8), .busy(busy8),
        .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on sign-extended values of width w.
    function automatic void model(input int w, input bit op, input bit sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz);
        longint      mask;
        longint      sa, sb_v, p, q, r;
        logic [63:0] pu;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(a) & mask;
        sb_v = longint'(b) & mask;
        if (sgn && a[w-1]) sa   = sa   - (longint'(1) << w);
        if (sgn && b[w-1]) sb_v = sb_v - (longint'(1) << w);
        dz = 1'b0;
        if (!op) begin
            p  = sa * sb_v;
            pu = p;
            lo = 32'(pu & mask);
            hi = 32'((pu >> w) & mask);
        end else if (sb_v == 0) begin
            hi = 32'(longint'(a) & mask);
            lo = 32'(mask);
            dz = 1'b1;
        end else begin
            q  = sa / sb_v;
            r  = sa % sb_v;
            lo = 32'(q & mask);
            hi = 32'(r & mask);
        end
    endfunction

    // Monitor: pops expectations on done, otherwise checks hi/lo hold.
    bit          mon_en = 1'b0;
    logic [31:0] last_hi = '0, last_lo = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (done32) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done32), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hi", 64'(hi32), 64'(e.hi));
                    chk("lo", 64'(lo32), 64'(e.lo));
                    chk("div_zero", 64'(dz32), 64'(e.dz));
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
                last_hi = hi32;
                last_lo = lo32;
            end else begin
                chk("hold", {hi32, lo32}, {last_hi, last_lo});
            end
        end
    end

    // Wait (at negedges) until the 32-bit DUT is idle, then present one start.
    task automatic issue32(input bit op, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit expect_it);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while ((busy32 || done32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'(busy32), 64'd0);
        model(32, op, sgn, a, b, e.hi, e.lo, e.dz);
        e.cyc = cyc + 1 + (e.dz ? 0 : W + 1);
        if (expect_it) sb.push_back(e);
        start32 = 1'b1; op32 = op; sgn32 = sgn; opa32 = a; opb32 = b;
        @(negedge clk);
        // Scramble inputs; only the accepted operands may matter.
        start32 = 1'b0;
        op32  = 1'($urandom);
        sgn32 = 1'($urandom);
        opa32 = $urandom;
        opb32 = $urandom;
    endtask

    task automatic run8(input bit op, input bit sgn, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] eh, el;
        logic        ed;
        int          c0, n;
        model(8, op, sgn, {24'd0, a}, {24'd0, b}, eh, el, ed);
        @(negedge clk);
        n = 0;
        while ((busy8 || done8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        start8 = 1'b1; op8 = op; sgn8 = sgn; opa8 = a; opb8 = b;
        c0 = cyc + 1;
        @(negedge clk);
        start8 = 1'b0; opa8 = 8'($urandom); opb8 = 8'($urandom);
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("w8_done_seen", 64'(done8), 64'd1);
        chk("w8_latency", 64'(cyc - c0), 64'(ed ? 0 : 9));
        chk("w8_hi", 64'(hi8), 64'(eh[7:0]));
        chk("w8_lo", 64'(lo8), 64'(el[7:0]));
        chk("w8_dz", 64'(dz8), 64'(ed));
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit ok;
        int n;

        // Reset both instances and check reset values.
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_dz", 64'(dz32), 64'd0);
        chk("rst_hilo", {hi32, lo32}, 64'd0);
        rst32 = 1'b1;
        rst8  = 1'b1;
        mon_en = 1'b1;

        // MULT -3 * 5 with busy window check.
        issue32(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1);
        ok = 1'b1;
        for (int i = 1; i <= W + 1; i++) begin
            if (busy32 !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        chk("busy_window", 64'(ok), 64'd1);
        chk("busy_in_done", 64'(busy32), 64'd0);

        issue32(1'b1, 1'b0, 32'd100, 32'd7, 1'b1);
        issue32(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue32(1'b1, 1'b1, 32'h1234_5678, 32'd0, 1'b1);
        issue32(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        // Non-zero divide after a divide-by-zero must clear div_zero.
        issue32(1'b1, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue32(1'b1, 1'b0, 32'd9, 32'd3, 1'b1);

        // Cancel in CALC: no done, hi/lo hold, busy drops next cycle.
        issue32(1'b0, 1'b1, 32'd1234, 32'd5678, 1'b0);
        repeat (8) @(negedge clk);
        cancel32 = 1'b1;
        @(negedge clk);
        cancel32 = 1'b0;
        chk("busy_after_cancel", 64'(busy32), 64'd0);
        issue32(1'b0, 1'b1, 32'hFFFF_FF00, 32'd300, 1'b1);

        // Start pulsed while busy must be ignored.
        issue32(1'b1, 1'b0, 32'd1000, 32'd33, 1'b1);
        repeat (3) @(negedge clk);
        start32 = 1'b1; op32 = 1'b0; opa32 = 32'd77; opb32 = 32'd88;
        @(negedge clk);
        start32 = 1'b0;

        // Cancel together with start in IDLE: nothing accepted.
        n = 0;
        while ((busy32 || done32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        start32 = 1'b1; cancel32 = 1'b1; op32 = 1'b0; opa32 = 32'd5; opb32 = 32'd6;
        @(negedge clk);
        start32 = 1'b0; cancel32 = 1'b0;
        chk("cancel_start_busy", 64'(busy32), 64'd0);

        // Randomised operations.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = pick32();
            b = pick32();
            issue32(1'($urandom), 1'($urandom), a, b, 1'b1);
        end

        // Drain the scoreboard.
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // 8-bit instance.
        run8(1'b1, 1'b1, 8'h9C, 8'h07);
        run8(1'b1, 1'b1, 8'h80, 8'hFF);
        run8(1'b1, 1'b0, 8'h55, 8'h00);
        run8(1'b0, 1'b1, 8'h80, 8'h80);
        for (int i = 0; i < 10; i++) begin
            run8(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end

        // Reset mid-CALC on the 8-bit instance aborts without done.
        @(negedge clk);
        start8 = 1'b1; op8 = 1'b0; sgn8 = 1'b0; opa8 = 8'd12; opb8 = 8'd13;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        chk("w8_rst_outputs", {busy8, done8, dz8, hi8, lo8}, 64'd0);
        rst8 = 1'b1;
        ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) ok = 1'b0;
        end
        chk("w8_no_done_after_rst", 64'(ok), 64'd1);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
